ccsds_asm_serializer: RTL and testbench
=======================================

# ccsds_asm_serializer

Upstream feeder of the CCSDS convolutional encoder. Accepts payload bytes over a valid/ready handshake, prepends the 32-bit Attached Sync Marker (0x1ACFFC1D), and emits the frame MSB-first as a paced bit stream. Each bit is held for 2×cycles_per_bit clocks, one input bit per rate-1/2 symbol pair. The output port set (data_o, valid_o, cycles_per_bit_o) connects directly to the encoder's data_i, valid_i and cycles_per_bit_i.

## Interface
- FRAME_BYTES, 16: payload bytes per frame, excluding the ASM. Legal range 1..4096.
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  asynchronous reset, active-high.
- data_i  in  8  payload byte, transmitted MSB first.
- valid_i  in  1  data_i is valid; in IDLE, also a frame-start request.
- ready_o  out  1  byte accepted on a rising edge where valid_i && ready_o.
- cycles_per_bit_i  in  32  symbol period in clocks; 0 is treated as 1.
- data_o  out  1  serial bit to the encoder.
- valid_o  out  1  data_o is valid.
- cycles_per_bit_o  out  32  value latched at frame start, forwarded to the encoder.
- underrun_o  out  1  one-cycle pulse when a frame is aborted for missing payload.

## Operation
- States:
  - IDLE: valid_i=1 → ASM. Latch cpb = max(cycles_per_bit_i, 1). Do not consume the byte.
  - ASM: shift out 32 ASM bits, then → PAYLOAD.
  - PAYLOAD: FRAME_BYTES×8 bits, then → IDLE. A missing byte at a byte boundary → IDLE with an underrun_o pulse.
- Bit period: a 33-bit counter counts 0..2·cpb−1. data_o changes only when the counter wraps.
- Holding register: one byte, hold_full flag.
  - ready_o = !hold_full && state∈{ASM, PAYLOAD} && bytes_fetched < FRAME_BYTES.
  - A byte may therefore be accepted during ASM, ahead of the first payload bit.
- Byte boundary (ASM bit 31 done, or payload bit 7 done):
  - Load the shift register from the holding register and clear hold_full.
  - If hold_full=0 at that point: underrun.
  - A handshake in the same cycle as the load sets hold_full (accept has priority after the load).
- cycles_per_bit_i changes after frame start are ignored until the next IDLE→ASM transition.
- Outputs are registered. data_o is held at 0 whenever valid_o=0.

## Timing
- Reset values: data_o=0, valid_o=0, ready_o=0, cycles_per_bit_o=0, underrun_o=0, state=IDLE, all counters 0, hold_full=0.
- Frame start: valid_i high in IDLE at edge k. At edge k+1, valid_o=1, data_o=ASM[31], cycles_per_bit_o=cpb.
- Bit n of the frame: presented from cycle k+1+2·cpb·n, held for exactly 2·cpb cycles.
- Frame length: (32+8·FRAME_BYTES)·2·cpb cycles. valid_o falls on the edge that ends the last bit period.
- Frame spacing: at least one IDLE cycle between frames. Back-to-back requests start at the earliest one cycle after valid_o falls.
- Underrun: valid_o and data_o drop to 0 on the boundary edge. underrun_o=1 for that cycle only. The holding register is cleared.
- Reset mid-frame: all outputs return to reset values asynchronously. The partial frame is discarded and no underrun_o pulse is generated.
- FRAME_BYTES=1: the single byte must be accepted before the 32nd ASM bit period ends.

## Structure
- Package ccsds_pkg holds:
  - CCSDS_ASM = 32'h1ACFFC1D and ASM_BITS = 32.
  - The serializer state enum, shared with later framing blocks.
- Sub-module ccsds_bit_timer: counts 2·cpb clocks and outputs a one-cycle wrap tick, with start/clear inputs. Reusable by the downstream modulator.
- Top level holds the FSM, the 8-bit shift register, the holding register, a 3-bit bit counter, and byte counters of width $clog2(FRAME_BYTES+1).

## Test plan
- Reset: assert rst_i mid-clock → all outputs are 0 immediately. Release → ready_o stays 0 until valid_i is asserted.
- Nominal frame: FRAME_BYTES=16, cpb=4, payload 0x48454C4C4F2C4954532D534147452100 streamed with valid_i always high.
  - data_o sampled every 8 cycles equals 160'h1ACFFC1D48454C4C4F2C4954532D534147452100, MSB first.
  - Chained into the encoder, the symbols equal 320'h56081C971AA73D3E790D72AA1536B546B54BCDC0757ECD65DA2366C3CA535321D2D4E41A20D72925.
  - valid_o stays high for exactly 1280 cycles.
- cpb latch: start a frame with cpb=6, then change to 2 mid-frame → every bit is still held 12 cycles, and cycles_per_bit_o=6 throughout.
- cpb=0 → each bit is held 2 cycles, and cycles_per_bit_o=1.
- Underrun: withhold byte 5 → valid_o falls at the end of payload bit 39, underrun_o pulses once, ready_o=0, and the next valid_i starts a fresh ASM.
- Reset mid-payload: assert rst_i at payload bit 20, release, then start a new frame → the output is a clean ASM plus a full payload, with no stale holding-register byte.

Source files
------------

// File: rtl/ccsds_pkg.sv
// Shared CCSDS framing definitions: sync marker constant and
// serializer state encoding used by the framing blocks.
package ccsds_pkg;

    localparam logic [31:0] CCSDS_ASM = 32'h1ACFFC1D;
    localparam int          ASM_BITS  = 32;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_ASM,
        SER_PAYLOAD
    } ser_state_e;

    // Byte idx of the marker, 0 being the first byte on the wire.
    function automatic logic [7:0] asm_byte(input logic [1:0] idx);
        logic [31:0] w;
        w = CCSDS_ASM << {idx, 3'b000};
        return w[31:24];
    endfunction

endpackage

// File: rtl/ccsds_bit_timer.sv
// Bit-period timer: counts 2*cycles_per_bit clocks and emits a
// one-cycle tick on the last clock of each period.
module ccsds_bit_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        clear_i,
    input  logic [31:0] cycles_per_bit_i,
    output logic        tick_o
);

    logic [32:0] cnt;
    logic [32:0] last;
    logic        running;

    assign last   = {cycles_per_bit_i, 1'b0} - 33'd1;
    assign tick_o = running && (cnt == last);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (clear_i) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start_i) begin
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            cnt <= tick_o ? '0 : cnt + 33'd1;
        end
    end

endmodule

// File: rtl/ccsds_asm_serializer.sv
// Prepends the CCSDS sync marker to a payload frame and emits it
// MSB-first as a paced bit stream for the convolutional encoder.
module ccsds_asm_serializer
    import ccsds_pkg::*;
#(
    parameter int FRAME_BYTES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] cycles_per_bit_i,
    output logic        data_o,
    output logic        valid_o,
    output logic [31:0] cycles_per_bit_o,
    output logic        underrun_o
);

    localparam int            CW   = $clog2(FRAME_BYTES + 1);
    localparam int            AW   = $clog2(ASM_BITS / 8);
    localparam logic [CW-1:0] LAST = CW'(FRAME_BYTES);

    ser_state_e    state, state_d;
    logic [31:0]   cpb_q;
    logic [7:0]    sreg;
    logic [7:0]    hold;
    logic          hold_full;
    logic [2:0]    bit_cnt;
    logic [AW-1:0] asm_idx;
    logic [CW-1:0] fetched;
    logic [CW-1:0] sent;
    logic          valid_q;
    logic          underrun_q;

    logic tick, boundary, accept;
    logic start, load_pay, underrun, done;

    ccsds_bit_timer u_timer (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start),
        .clear_i          (done || underrun),
        .cycles_per_bit_i (cpb_q),
        .tick_o           (tick)
    );

    assign ready_o = !hold_full
                   && (state == SER_ASM || state == SER_PAYLOAD)
                   && (fetched < LAST);
    assign accept   = valid_i && ready_o;
    assign boundary = tick && (bit_cnt == 3'd7);

    assign data_o           = sreg[7];
    assign valid_o          = valid_q;
    assign cycles_per_bit_o = cpb_q;
    assign underrun_o       = underrun_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= SER_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d  = state;
        start    = 1'b0;
        load_pay = 1'b0;
        underrun = 1'b0;
        done     = 1'b0;
        unique case (state)
            SER_IDLE: begin
                if (valid_i) begin
                    start   = 1'b1;
                    state_d = SER_ASM;
                end
            end
            SER_ASM: begin
                if (boundary && asm_idx == '0) begin
                    if (hold_full) begin
                        load_pay = 1'b1;
                        state_d  = SER_PAYLOAD;
                    end else begin
                        underrun = 1'b1;
                        state_d  = SER_IDLE;
                    end
                end
            end
            SER_PAYLOAD: begin
                if (boundary) begin
                    if (sent == LAST) begin
                        done    = 1'b1;
                        state_d = SER_IDLE;
                    end else if (hold_full) begin
                        load_pay = 1'b1;
                    end else begin
                        underrun = 1'b1;
                        state_d  = SER_IDLE;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    // sreg is zeroed whenever the stream is idle so data_o reads 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpb_q      <= '0;
            sreg       <= '0;
            bit_cnt    <= '0;
            asm_idx    <= '0;
            sent       <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun;
            if (start) begin
                cpb_q   <= (cycles_per_bit_i == '0) ? 32'd1
                                                    : cycles_per_bit_i;
                sreg    <= asm_byte(2'd0);
                asm_idx <= AW'(1);
                bit_cnt <= '0;
                sent    <= '0;
                valid_q <= 1'b1;
            end else if (done || underrun) begin
                sreg    <= '0;
                bit_cnt <= '0;
                valid_q <= 1'b0;
            end else if (tick) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt != 3'd7) begin
                    sreg <= {sreg[6:0], 1'b0};
                end else if (load_pay) begin
                    sreg <= hold;
                    sent <= sent + 1'b1;
                end else begin
                    sreg    <= asm_byte(asm_idx);
                    asm_idx <= asm_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold      <= '0;
            hold_full <= 1'b0;
            fetched   <= '0;
        end else if (start) begin
            hold_full <= 1'b0;
            fetched   <= '0;
        end else if (underrun) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= data_i;
            hold_full <= 1'b1;
            fetched   <= fetched + 1'b1;
        end else if (load_pay) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ccsds_asm_serializer.sv
// Randomized bench for ccsds_asm_serializer against a bit-list
// reference of marker plus payload, each bit held 2*cpb clocks.
module tb_ccsds_asm_serializer;

    localparam int           FB      = 16;
    localparam logic [31:0]  ASM     = 32'h1ACFFC1D;
    localparam logic [159:0] NOMINAL =
        160'h1ACFFC1D48454C4C4F2C4954532D534147452100;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] cycles_per_bit_i;
    logic        data_o;
    logic        valid_o;
    logic [31:0] cycles_per_bit_o;
    logic        underrun_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   pl [FB];
    logic [159:0] nom;

    ccsds_asm_serializer #(.FRAME_BYTES(FB)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .data_i           (data_i),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .cycles_per_bit_i (cycles_per_bit_i),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .cycles_per_bit_o (cycles_per_bit_o),
        .underrun_o       (underrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] got,
                         input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".valid_o"}, valid_o, 0);
        check({tag, ".data_o"}, data_o, 0);
        check({tag, ".ready_o"}, ready_o, 0);
        check({tag, ".cpb_o"}, cycles_per_bit_o, 0);
        check({tag, ".underrun_o"}, underrun_o, 0);
    endtask

    task automatic randomize_payload();
        for (int b = 0; b < FB; b++) pl[b] = 8'($urandom);
    endtask

    // hold_at >= 0 withholds that byte index; abort_at >= 0 resets
    // mid-clock at that sample index and skips the frame summary.
    task automatic run_frame(input string tag, input int unsigned cpb_req,
                             input int unsigned cpb_alt, input int hold_at,
                             input bit gaps, input int abort_at,
                             input bit chk_word);
        int unsigned  cpb_eff;
        int           per, nbits, len, idx;
        int           vbad, dbad, zbad, cbad, upulse, uat;
        bit           fire;
        logic         bits[$];
        logic [159:0] word;
        cpb_eff = (cpb_req == 0) ? 1 : cpb_req;
        per     = 2 * int'(cpb_eff);
        nbits   = (hold_at >= 0) ? 32 + 8 * hold_at : 32 + 8 * FB;
        len     = nbits * per;
        idx = 0; vbad = 0; dbad = 0; zbad = 0; cbad = 0;
        upulse = 0; uat = -1; word = '0;
        for (int i = 0; i < 32; i++) bits.push_back(ASM[31-i]);
        for (int b = 0; b < FB; b++)
            for (int j = 0; j < 8; j++) bits.push_back(pl[b][7-j]);

        @(posedge clk); #1;
        cycles_per_bit_i = cpb_req;
        valid_i          = 1'b1;
        data_i           = pl[0];
        @(posedge clk); #1;

        for (int c = 0; c < len + 4; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                check({tag, ".pre_valid"}, valid_o, 1);
                #2 rst_i = 1'b1;
                #1;
                check_reset_outputs({tag, ".async"});
                valid_i = 1'b0;
                @(posedge clk); #1 rst_i = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                return;
            end
            if (valid_o !== (c < len)) vbad++;
            if (valid_o === 1'b1) begin
                if (c < len && data_o !== bits[c/per]) dbad++;
                if (cycles_per_bit_o !== cpb_eff) cbad++;
                if (c % per == 0 && c / per < 160)
                    word = {word[158:0], data_o};
            end else if (data_o !== 1'b0) begin
                zbad++;
            end
            if (underrun_o === 1'b1) begin
                upulse++;
                uat = c;
            end
            fire = valid_i && ready_o;
            @(posedge clk); #1;
            if (fire) idx++;
            if (c == len / 3) cycles_per_bit_i = cpb_alt;
            valid_i = (idx < FB) && (hold_at < 0 || idx < hold_at)
                      && !(gaps && $urandom_range(0, 3) == 0);
            data_i  = (idx < FB) ? pl[idx] : 8'h00;
        end

        check({tag, ".valid_window"}, vbad, 0);
        check({tag, ".bits"}, dbad, 0);
        check({tag, ".idle_zero"}, zbad, 0);
        check({tag, ".cpb_o"}, cbad, 0);
        check({tag, ".underrun_cnt"}, upulse, (hold_at >= 0) ? 1 : 0);
        if (hold_at >= 0) check({tag, ".underrun_at"}, uat, len);
        check({tag, ".bytes_taken"}, idx, (hold_at >= 0) ? hold_at : FB);
        check({tag, ".ready_after"}, ready_o, 0);
        if (chk_word) check({tag, ".word160"}, word, NOMINAL);
    endtask

    initial begin
        rst_i            = 1'b1;
        valid_i          = 1'b0;
        data_i           = 8'h00;
        cycles_per_bit_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("idle.ready", ready_o, 0);
        end

        nom = NOMINAL;
        for (int b = 0; b < FB; b++) pl[b] = nom[127-8*b -: 8];
        run_frame("nominal", 4, 4, -1, 1'b0, -1, 1'b1);

        for (int r = 0; r < 3; r++) begin
            randomize_payload();
            run_frame($sformatf("rand%0d", r), $urandom_range(1, 5),
                      $urandom_range(1, 5), -1, 1'b1, -1, 1'b0);
        end

        randomize_payload();
        run_frame("cpb_latch", 6, 2, -1, 1'b1, -1, 1'b0);

        randomize_payload();
        run_frame("cpb_zero", 0, 0, -1, 1'b0, -1, 1'b0);

        randomize_payload();
        run_frame("underrun", 2, 2, 5, 1'b0, -1, 1'b0);

        randomize_payload();
        run_frame("post_underrun", 3, 3, -1, 1'b1, -1, 1'b0);

        randomize_payload();
        run_frame("abort", 2, 2, -1, 1'b0, (32 + 20) * 4 + 2, 1'b0);
        check_reset_outputs("post_abort");

        randomize_payload();
        run_frame("post_reset", 2, 2, -1, 1'b1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
